mem_scan_ctrl: RTL

MEM_SCAN_CTRL -- requirements
Module: mem_scan_ctrl

---
 rtl/mem_scan_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_scan_ctrl.sv
// Memory scan controller: steps through one of several memory banks at a
// selectable rate, fetching one word per step for display, with pause/step/bank controls.
module mem_scan_ctrl #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int NUM_BANKS  = 2,
  parameter int SPD_LEVELS = 4,
  parameter int TIMEOUT    = 16,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int SPD_W     = (SPD_LEVELS > 1) ? $clog2(SPD_LEVELS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_pause,
  input  logic              btn_spdup,
  input  logic              btn_spddn,
  input  logic              btn_step,
  input  logic              btn_bank,
  output logic              rd_en,
  output logic [BANK_W-1:0] rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] disp_data,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [BANK_W-1:0] disp_bank,
  output logic [SPD_W-1:0]  spd_level,
  output logic              paused,
  output logic              rd_err
);

  localparam int TICK_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_RUN, S_FETCH, S_PAUSED} state_t;

  state_t              state_reg, state_next;
  logic                armed_reg;
  logic [ADDR_W-1:0]   cur_addr_reg, cur_addr_next;
  logic [BANK_W-1:0]   cur_bank_reg, cur_bank_next;
  logic [SPD_W-1:0]    spd_reg, spd_next;
  logic                paused_reg, paused_next;
  logic [TICK_W-1:0]   tick_reg, tick_next;
  logic [TO_W-1:0]     to_cnt_reg, to_cnt_next;
  logic [DATA_W-1:0]   disp_data_reg, disp_data_next;
  logic [ADDR_W-1:0]   disp_addr_reg, disp_addr_next;
  logic [BANK_W-1:0]   disp_bank_reg, disp_bank_next;
  logic                rd_err_reg, rd_err_next;
  logic [ADDR_W-1:0]   addr_inc;
  logic [BANK_W-1:0]   bank_inc;

  // Terminal tick value per speed level; level k halves the period, never below 1.
  logic [TICK_W-1:0] period_m1 [SPD_LEVELS];
  for (genvar gi = 0; gi < SPD_LEVELS; gi++) begin : g_period
    localparam int PER = ((CLK_FREQ >> gi) > 0) ? (CLK_FREQ >> gi) : 1;
    assign period_m1[gi] = TICK_W'(PER - 1);
  end

  assign addr_inc = cur_addr_reg + ADDR_W'(1);
  assign bank_inc = (cur_bank_reg == BANK_W'(NUM_BANKS - 1)) ? '0 : cur_bank_reg + BANK_W'(1);

  always_comb begin
    state_next     = state_reg;
    cur_addr_next  = cur_addr_reg;
    cur_bank_next  = cur_bank_reg;
    tick_next      = '0;
    to_cnt_next    = '0;
    paused_next    = paused_reg ^ btn_pause;
    disp_data_next = disp_data_reg;
    disp_addr_next = disp_addr_reg;
    disp_bank_next = disp_bank_reg;
    rd_err_next    = 1'b0;

    spd_next = spd_reg;
    if (btn_spdup && !btn_spddn && spd_reg != SPD_W'(SPD_LEVELS - 1))
      spd_next = spd_reg + SPD_W'(1);
    else if (btn_spddn && !btn_spdup && spd_reg != '0)
      spd_next = spd_reg - SPD_W'(1);

    case (state_reg)
      S_RUN: begin
        if (btn_pause) begin
          state_next = S_PAUSED;
        end else if (btn_bank) begin
          cur_bank_next = bank_inc;
          state_next    = S_FETCH;
        end else if (spd_next != spd_reg) begin
          tick_next = '0;
        end else if (tick_reg == period_m1[spd_reg]) begin
          cur_addr_next = addr_inc;
          state_next    = S_FETCH;
        end else begin
          tick_next = tick_reg + TICK_W'(1);
        end
      end
      S_PAUSED: begin
        if (btn_pause) begin
          state_next = S_RUN;
        end else if (btn_bank) begin
          cur_bank_next = bank_inc;
          state_next    = S_FETCH;
        end else if (btn_step) begin
          cur_addr_next = addr_inc;
          state_next    = S_FETCH;
        end
      end
      S_FETCH: begin
        // The first cycle out of reset sits here unarmed, so no request is issued yet.
        if (armed_reg) begin
          if (rd_valid) begin
            disp_data_next = rd_data;
            disp_addr_next = cur_addr_reg;
            disp_bank_next = cur_bank_reg;
            state_next     = paused_next ? S_PAUSED : S_RUN;
          end else if (to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
            disp_data_next = '1;
            disp_addr_next = cur_addr_reg;
            disp_bank_next = cur_bank_reg;
            rd_err_next    = 1'b1;
            state_next     = paused_next ? S_PAUSED : S_RUN;
          end else begin
            to_cnt_next = to_cnt_reg + TO_W'(1);
          end
        end
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_FETCH;
      armed_reg     <= 1'b0;
      cur_addr_reg  <= '0;
      cur_bank_reg  <= '0;
      spd_reg       <= '0;
      paused_reg    <= 1'b0;
      tick_reg      <= '0;
      to_cnt_reg    <= '0;
      disp_data_reg <= '0;
      disp_addr_reg <= '0;
      disp_bank_reg <= '0;
      rd_err_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      armed_reg     <= 1'b1;
      cur_addr_reg  <= cur_addr_next;
      cur_bank_reg  <= cur_bank_next;
      spd_reg       <= spd_next;
      paused_reg    <= paused_next;
      tick_reg      <= tick_next;
      to_cnt_reg    <= to_cnt_next;
      disp_data_reg <= disp_data_next;
      disp_addr_reg <= disp_addr_next;
      disp_bank_reg <= disp_bank_next;
      rd_err_reg    <= rd_err_next;
    end
  end

  // armed_reg clears asynchronously, so a reset mid-fetch drops the request at once.
  assign rd_en     = (state_reg == S_FETCH) && armed_reg;
  assign rd_addr   = cur_addr_reg;
  assign rd_bank   = cur_bank_reg;
  assign disp_data = disp_data_reg;
  assign disp_addr = disp_addr_reg;
  assign disp_bank = disp_bank_reg;
  assign spd_level = spd_reg;
  assign paused    = paused_reg;
  assign rd_err    = rd_err_reg;

endmodule
